// File: rtl/fifo_drain_serializer.sv
// ---------------------------------------------------------------------------
// fifo_drain_serializer
//
// Pulls words out of an upstream FIFO one at a time and sends each one as a
// serial frame: a start bit (0), FIFO_WIDTH data bits LSB-first, and a stop
// bit (1). Every bit lasts CLKS_PER_BIT clocks. If a read comes back with the
// underflow flag set, the word is dropped and a sticky error flag is raised.
//
// Parameters
//   FIFO_WIDTH    data word width; must match the upstream FIFO
//   CLKS_PER_BIT  clocks per serial bit (2 or more)
//
// Ports
//   clk             in   clock; all state changes on the rising edge
//   rst             in   asynchronous active-high reset
//   en              in   allows new frames to start
//   fifo_empty      in   upstream FIFO empty flag
//   fifo_data_out   in   FIFO read data, valid the cycle after fifo_rd_en
//   fifo_underflow  in   FIFO underflow flag, valid with fifo_data_out
//   err_clr         in   clears the sticky error flag
//   fifo_rd_en      out  one-cycle read strobe to the FIFO
//   tx              out  serial line, idle high
//   busy            out  high whenever the FSM is not idle
//   frame_done      out  one-cycle pulse in the last stop-bit cycle
//   err             out  sticky flag for a read that returned underflow
// ---------------------------------------------------------------------------
module fifo_drain_serializer #(
  parameter int FIFO_WIDTH   = 16,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  fifo_empty,
  input  logic [FIFO_WIDTH-1:0] fifo_data_out,
  input  logic                  fifo_underflow,
  input  logic                  err_clr,
  output logic                  fifo_rd_en,
  output logic                  tx,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  err
);

  localparam int BAUD_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W  = $clog2(FIFO_WIDTH + 1);

  localparam logic [BAUD_W-1:0] BAUD_ZERO = {BAUD_W{1'b0}};
  localparam logic [BAUD_W-1:0] BAUD_ONE  = BAUD_W'(1);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  BIT_ZERO  = {BIT_W{1'b0}};
  localparam logic [BIT_W-1:0]  BIT_ONE   = BIT_W'(1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(FIFO_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    START = 3'd3,
    DATA  = 3'd4,
    STOP  = 3'd5
  } state_t;

  state_t                  state_r;
  state_t                  state_next_s;
  logic [BAUD_W-1:0]       baud_cnt_r;
  logic [BAUD_W-1:0]       baud_next_s;
  logic [BIT_W-1:0]        bit_cnt_r;
  logic [BIT_W-1:0]        bit_next_s;
  logic [FIFO_WIDTH-1:0]   shift_r;
  logic [FIFO_WIDTH-1:0]   shift_next_s;

  logic                    tx_r;
  logic                    tx_next_s;
  logic                    fifo_rd_en_r;
  logic                    busy_r;
  logic                    frame_done_r;
  logic                    frame_done_next_s;
  logic                    err_r;
  logic                    err_next_s;

  // Next-state, counter and shift-register logic.
  always_comb begin
    state_next_s = state_r;
    baud_next_s  = baud_cnt_r;
    bit_next_s   = bit_cnt_r;
    shift_next_s = shift_r;

    case (state_r)
      IDLE: begin
        baud_next_s = BAUD_ZERO;
        if (en && !fifo_empty) begin
          state_next_s = REQ;
        end else begin
          state_next_s = IDLE;
        end
      end

      REQ: begin
        state_next_s = WAIT;
      end

      WAIT: begin
        baud_next_s = BAUD_ZERO;
        if (fifo_underflow) begin
          // The word is garbage: drop it and go back to idle.
          state_next_s = IDLE;
        end else begin
          state_next_s = START;
          shift_next_s = fifo_data_out;
        end
      end

      START: begin
        if (baud_cnt_r == BAUD_LAST) begin
          state_next_s = DATA;
          baud_next_s  = BAUD_ZERO;
          bit_next_s   = BIT_ZERO;
        end else begin
          baud_next_s  = baud_cnt_r + BAUD_ONE;
        end
      end

      DATA: begin
        if (baud_cnt_r == BAUD_LAST) begin
          // Bit boundary: expose the next data bit on shift_r[0].
          baud_next_s  = BAUD_ZERO;
          shift_next_s = {1'b0, shift_r[FIFO_WIDTH-1:1]};
          bit_next_s   = bit_cnt_r + BIT_ONE;
          if (bit_cnt_r == BIT_LAST) begin
            state_next_s = STOP;
          end else begin
            state_next_s = DATA;
          end
        end else begin
          baud_next_s  = baud_cnt_r + BAUD_ONE;
        end
      end

      STOP: begin
        if (baud_cnt_r == BAUD_LAST) begin
          baud_next_s = BAUD_ZERO;
          if (en && !fifo_empty) begin
            state_next_s = REQ;
          end else begin
            state_next_s = IDLE;
          end
        end else begin
          baud_next_s = baud_cnt_r + BAUD_ONE;
        end
      end

      default: begin
        state_next_s = IDLE;
        baud_next_s  = BAUD_ZERO;
        bit_next_s   = BIT_ZERO;
      end
    endcase
  end

  // Output values for the coming cycle, derived from the next state so the
  // registered outputs line up exactly with the state they describe.
  always_comb begin
    tx_next_s         = 1'b1;
    frame_done_next_s = 1'b0;

    case (state_next_s)
      START:   tx_next_s = 1'b0;
      DATA:    tx_next_s = shift_next_s[0];
      default: tx_next_s = 1'b1;
    endcase

    if ((state_next_s == STOP) && (baud_next_s == BAUD_LAST)) begin
      frame_done_next_s = 1'b1;
    end else begin
      frame_done_next_s = 1'b0;
    end
  end

  // Sticky error: a WAIT underflow takes priority over a clear request.
  always_comb begin
    err_next_s = err_r;
    if ((state_r == WAIT) && fifo_underflow) begin
      err_next_s = 1'b1;
    end else if (err_clr) begin
      err_next_s = 1'b0;
    end else begin
      err_next_s = err_r;
    end
  end

  // State, counters, shift register and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= IDLE;
      baud_cnt_r   <= BAUD_ZERO;
      bit_cnt_r    <= BIT_ZERO;
      shift_r      <= {FIFO_WIDTH{1'b0}};
      tx_r         <= 1'b1;
      fifo_rd_en_r <= 1'b0;
      busy_r       <= 1'b0;
      frame_done_r <= 1'b0;
      err_r        <= 1'b0;
    end else begin
      state_r      <= state_next_s;
      baud_cnt_r   <= baud_next_s;
      bit_cnt_r    <= bit_next_s;
      shift_r      <= shift_next_s;
      tx_r         <= tx_next_s;
      fifo_rd_en_r <= (state_next_s == REQ);
      busy_r       <= (state_next_s != IDLE);
      frame_done_r <= frame_done_next_s;
      err_r        <= err_next_s;
    end
  end

  assign fifo_rd_en = fifo_rd_en_r;
  assign tx         = tx_r;
  assign busy       = busy_r;
  assign frame_done = frame_done_r;
  assign err        = err_r;

endmodule

// File: tb/tb_fifo_drain_serializer.sv
module tb_fifo_drain_serializer;

  localparam int W     = 16;
  localparam int C     = 4;
  localparam int FRAME = (W + 2) * C;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         en = 1'b0;
  logic         err_clr = 1'b0;
  logic         fifo_empty = 1'b1;
  logic         fifo_underflow = 1'b0;
  logic [W-1:0] fifo_data_out = '0;
  logic         fifo_rd_en;
  logic         tx;
  logic         busy;
  logic         frame_done;
  logic         err;

  fifo_drain_serializer #(.FIFO_WIDTH(W), .CLKS_PER_BIT(C)) dut (
    .clk            (clk),
    .rst            (rst),
    .en             (en),
    .fifo_empty     (fifo_empty),
    .fifo_data_out  (fifo_data_out),
    .fifo_underflow (fifo_underflow),
    .err_clr        (err_clr),
    .fifo_rd_en     (fifo_rd_en),
    .tx             (tx),
    .busy           (busy),
    .frame_done     (frame_done),
    .err            (err)
  );

  always #5 clk = ~clk;

  // Upstream FIFO contents and the scoreboard of words expected on tx.
  logic [W-1:0] fifo_q[$];
  logic [W-1:0] exp_q[$];
  bit           force_uf = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  int cyc_cnt      = 0;
  int rd_cnt       = 0;
  int frames_rx    = 0;
  int done_cnt     = 0;
  int last_len     = 0;
  int last_gap     = -1;
  int last_end_cyc = -100;
  bit in_frame     = 1'b0;
  int fcyc         = 0;
  logic [W-1:0] cur_exp = '0;
  logic [W+1:0] last_bits = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // FIFO model: registered read data and empty flag.
  always @(posedge clk) begin
    logic [W-1:0] w;
    if (fifo_rd_en) begin
      if (force_uf || fifo_q.size() == 0) begin
        fifo_underflow <= 1'b1;
        fifo_data_out  <= 16'hDEAD;
      end else begin
        w = fifo_q.pop_front();
        fifo_data_out  <= w;
        fifo_underflow <= 1'b0;
        exp_q.push_back(w);
      end
    end else begin
      fifo_underflow <= 1'b0;
    end
    fifo_empty <= (fifo_q.size() == 0);
  end

  // Monitor: recognises frames on tx and checks each cycle against the word
  // the FIFO handed out (start 0, data LSB-first, stop 1).
  always @(negedge clk) begin
    int   idx;
    logic exp_tx;
    cyc_cnt++;
    if (fifo_rd_en) rd_cnt++;
    if (rst) begin
      in_frame = 1'b0;
      fcyc     = 0;
      exp_q.delete();
    end else begin
      if (!in_frame && tx == 1'b0) begin
        in_frame = 1'b1;
        fcyc     = 0;
        last_gap = cyc_cnt - last_end_cyc - 1;
        check("exp_avail", (exp_q.size() > 0) ? 32'd1 : 32'd0, 32'd1);
        if (exp_q.size() > 0) cur_exp = exp_q.pop_front();
        else cur_exp = '0;
      end
      if (in_frame) begin
        fcyc++;
        idx = (fcyc - 1) / C;
        if (idx == 0) exp_tx = 1'b0;
        else if (idx <= W) exp_tx = cur_exp[idx-1];
        else exp_tx = 1'b1;
        check("tx_bit", tx, exp_tx);
        check("busy_in_frame", busy, 1'b1);
        if (((fcyc - 1) % C) == (C / 2) && idx <= W + 1) last_bits[idx] = tx;
        if (frame_done) begin
          check("frame_len", fcyc, FRAME);
          in_frame = 1'b0;
          frames_rx++;
          done_cnt++;
          last_len     = fcyc;
          last_end_cyc = cyc_cnt;
        end else if (fcyc >= FRAME) begin
          check("frame_done_pulse", frame_done, 1'b1);
          in_frame     = 1'b0;
          last_end_cyc = cyc_cnt;
        end
      end else begin
        check("no_stray_done", frame_done, 1'b0);
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_frames(input int target, input int budget, input string name);
    int n = 0;
    while (frames_rx < target && n < budget) begin
      tick();
      n++;
    end
    check(name, frames_rx, target);
  endtask

  task automatic wait_rd(input int budget, input string name);
    int n = 0;
    while (fifo_rd_en !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    check(name, fifo_rd_en, 1'b1);
  endtask

  task automatic wait_start(input int budget, input string name);
    int n = 0;
    while (!in_frame && n < budget) begin
      tick();
      n++;
    end
    check(name, in_frame, 1'b1);
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int rd0;
    int fr0;
    int dn0;
    logic [W+1:0] ref_seq;

    // Reset state
    repeat (3) tick();
    check("reset_outputs", {tx, fifo_rd_en, busy, frame_done, err}, 5'b10000);
    rst = 1'b0;
    tick();

    // Single word A5C3
    ref_seq = 18'b110100101110000110;
    rd0 = rd_cnt;
    fr0 = frames_rx;
    fifo_q.push_back(16'hA5C3);
    en = 1'b1;
    wait_frames(fr0 + 1, 300, "single_frame");
    check("single_len", last_len, FRAME);
    check("single_bits", last_bits, ref_seq);
    check("single_rd_pulses", rd_cnt - rd0, 1);
    tick();
    check("single_busy_fall", busy, 1'b0);
    en = 1'b0;
    tick();

    // Back-to-back frames
    rd0 = rd_cnt;
    fr0 = frames_rx;
    fifo_q.push_back(16'h0001);
    fifo_q.push_back(16'h8000);
    tick();
    en = 1'b1;
    wait_frames(fr0 + 2, 400, "b2b_frames");
    check("b2b_gap", last_gap, 2);
    check("b2b_rd_pulses", rd_cnt - rd0, 2);
    en = 1'b0;
    tick();

    // Underflow on read
    fifo_q.push_back(16'h1234);
    force_uf = 1'b1;
    dn0 = done_cnt;
    tick();
    en = 1'b1;
    wait_rd(50, "uf_rd_seen");
    en = 1'b0;
    tick();
    tick();
    check("uf_err_set", err, 1'b1);
    check("uf_tx_idle", {tx, busy}, 2'b10);
    repeat (5) tick();
    check("uf_err_sticky", err, 1'b1);
    check("uf_no_done", done_cnt - dn0, 0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("uf_err_clear", err, 1'b0);

    // Underflow and clear in the same cycle: set wins
    err_clr = 1'b1;
    en = 1'b1;
    wait_rd(50, "uf2_rd_seen");
    en = 1'b0;
    tick();
    tick();
    check("uf_set_wins", err, 1'b1);
    tick();
    check("uf_clear_after", err, 1'b0);
    err_clr  = 1'b0;
    force_uf = 1'b0;

    // The un-popped word is still there; send it normally
    fr0 = frames_rx;
    en = 1'b1;
    wait_frames(fr0 + 1, 300, "uf_recover_frame");
    en = 1'b0;
    tick();

    // en dropped during data bit 5
    rd0 = rd_cnt;
    fr0 = frames_rx;
    fifo_q.push_back(16'h5A5A);
    fifo_q.push_back(16'hC001);
    fifo_q.push_back(16'h7E81);
    tick();
    en = 1'b1;
    wait_start(50, "gate_start");
    repeat (25) tick();
    en = 1'b0;
    wait_frames(fr0 + 1, 200, "gate_frame");
    check("gate_len", last_len, FRAME);
    repeat (20) tick();
    check("gate_rd_pulses", rd_cnt - rd0, 1);
    check("gate_idle", busy, 1'b0);

    // Reset during data bit 8
    en = 1'b1;
    wait_start(50, "rst_frame_start");
    repeat (37) tick();
    dn0 = done_cnt;
    #1;
    rst = 1'b1;
    #1;
    check("rst_async_out", {tx, busy, frame_done}, 3'b100);
    repeat (3) tick();
    check("rst_hold_rd", fifo_rd_en, 1'b0);
    rst = 1'b0;
    fr0 = frames_rx;
    wait_rd(50, "rst_next_req");
    check("rst_req_tx_high", tx, 1'b1);
    check("rst_no_done", done_cnt - dn0, 0);
    wait_frames(fr0 + 1, 200, "rst_next_frame");

    // Empty FIFO for 100 cycles
    en = 1'b1;
    tick();
    for (int i = 0; i < 100; i++) begin
      check("empty_idle", {fifo_rd_en, tx, busy}, 3'b010);
      tick();
    end

    // Random words with random en activity
    fr0 = frames_rx;
    for (int i = 0; i < 8; i++) begin
      fifo_q.push_back(16'($urandom));
      for (int j = 0; j < int'($urandom_range(0, 100)); j++) begin
        en = ($urandom_range(0, 3) != 0);
        tick();
      end
    end
    en = 1'b1;
    wait_frames(fr0 + 8, 1500, "random_frames");
    repeat (4) tick();
    check("random_drained", fifo_q.size() + exp_q.size(), 0);
    check("random_idle", busy, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_drain_serializer.md
FIFO_DRAIN_SERIALIZER -- requirements
Module: fifo_drain_serializer

Interface
REQ-001 Parameter FIFO_WIDTH, default 16, SHALL set the data word width and match the upstream FIFO_WIDTH.
REQ-002 Parameter CLKS_PER_BIT, default 4, SHALL set the clock cycles per serial bit; legal values are 2 or more.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be the reset: asynchronous, active-high.
REQ-005 en  input  1  SHALL enable the start of new frames.
REQ-006 fifo_empty  input  1  SHALL be the empty flag from the upstream FIFO.
REQ-007 fifo_data_out  input  FIFO_WIDTH  SHALL be the FIFO read data, valid the cycle after fifo_rd_en is sampled.
REQ-008 fifo_underflow  input  1  SHALL be the FIFO underflow flag, valid with fifo_data_out.
REQ-009 err_clr  input  1  SHALL clear the sticky error flag.
REQ-010 fifo_rd_en  output  1  SHALL be the read strobe to the FIFO.
REQ-011 tx  output  1  SHALL be the serial line, idle high.
REQ-012 busy  output  1  SHALL be high whenever the FSM is not in IDLE.
REQ-013 frame_done  output  1  SHALL be a one-cycle pulse marking the end of a frame.
REQ-014 err  output  1  SHALL be a sticky flag for a read that returned underflow.

Function
REQ-015 The FSM SHALL have exactly these states: IDLE, REQ, WAIT, START, DATA, STOP.
REQ-016 IDLE SHALL go to REQ when en=1 and fifo_empty=0; otherwise it SHALL stay in IDLE.
REQ-017 fifo_rd_en SHALL be 1 for exactly the single cycle spent in REQ and 0 in all other states; REQ SHALL always go to WAIT.
REQ-018 WAIT SHALL last one cycle and capture fifo_data_out into the shift register.
REQ-019 WAIT with fifo_underflow=1 SHALL set err, discard the word and go to IDLE; no frame SHALL be emitted.
REQ-020 WAIT with fifo_underflow=0 SHALL go to START.
REQ-021 START SHALL drive tx=0 for CLKS_PER_BIT cycles.
REQ-022 DATA SHALL drive FIFO_WIDTH bits LSB-first, each for CLKS_PER_BIT cycles, tracked by a bit counter of width ceil(log2(FIFO_WIDTH+1)).
REQ-023 STOP SHALL drive tx=1 for CLKS_PER_BIT cycles.
REQ-024 tx SHALL be 1 in IDLE, REQ and WAIT.
REQ-025 Each frame SHALL occupy exactly (FIFO_WIDTH+2)*CLKS_PER_BIT cycles, from the first START cycle to the last STOP cycle.
REQ-026 frame_done SHALL be 1 only in the last STOP cycle.
REQ-027 The last STOP cycle SHALL go to REQ if en=1 and fifo_empty=0, giving back-to-back frames with a 2-cycle gap (REQ+WAIT); otherwise it SHALL go to IDLE.
REQ-028 Deasserting en mid-frame SHALL NOT truncate the frame; it SHALL only block the next REQ.
REQ-029 fifo_empty rising during a frame SHALL NOT affect the frame in flight.
REQ-030 The baud counter SHALL count 0..CLKS_PER_BIT-1 and wrap to 0 at each bit boundary; the bit counter SHALL reset on entry to DATA.
REQ-031 err_clr=1 SHALL clear err on the next edge; if err_clr and a WAIT underflow occur in the same cycle, set SHALL win.

Reset
REQ-032 While rst=1, the block SHALL be in IDLE with tx=1, fifo_rd_en=0, busy=0, frame_done=0, err=0, and all counters and the shift register at 0.
REQ-033 rst asserted mid-frame SHALL abort the frame immediately, asynchronously driving tx to 1 with no completion pulse.
REQ-034 After rst deasserts, the first REQ SHALL occur no earlier than the first rising edge with rst=0.

Verification (FIFO_WIDTH=16, CLKS_PER_BIT=4)
REQ-035 Single word: FIFO holds 16'hA5C3, en=1 -> one fifo_rd_en pulse; tx sequence per bit is 0, 1,1,0,0,0,0,1,1, 1,0,1,0,0,1,0,1, 1; frame lasts 72 cycles; frame_done=1 in cycle 72; busy then falls.
REQ-036 Back-to-back: FIFO holds 16'h0001 then 16'h8000, en=1 -> two frames; exactly 2 tx-high cycles separate the stop bit of frame 1 from the start bit of frame 2; 2 fifo_rd_en pulses total.
REQ-037 Underflow: fifo_empty=0 but fifo_underflow=1 in the WAIT cycle -> err=1, tx stays 1, no frame_done; err_clr=1 for one cycle then returns err=0.
REQ-038 en gating: en drops during DATA bit 5 with the FIFO non-empty -> the current frame completes all 72 cycles; no further fifo_rd_en while en=0.
REQ-039 Reset mid-frame: rst=1 during DATA bit 8 -> tx=1 and busy=0 immediately, frame_done never pulses; after release with en=1 and the FIFO non-empty, the next frame starts with REQ.
REQ-040 Empty FIFO: en=1, fifo_empty=1 for 100 cycles -> fifo_rd_en=0, tx=1 and busy=0 throughout.
